// File: rtl/stage_sequencer_pkg.sv
// Shared Y86 sequencer definitions: data width, FSM state encodings,
// status codes and instruction codes.
package stage_sequencer_pkg;

    localparam int DATA_WID = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        PC_UPD    = 3'd6,
        HALT      = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        AOK = 4'd1,
        HLT = 4'd2,
        ADR = 4'd3,
        INS = 4'd4
    } stat_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/stage_sequencer_icode_stage_decode.sv
// Per-icode stage usage: which optional stages run and which write
// enables they raise. Purely combinational.
module icode_stage_decode
    import stage_sequencer_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    output logic       needs_mem,
    output logic       mem_write,
    output logic       needs_wb,
    output logic       we_e,
    output logic       we_m,
    output logic       sets_cc
);

    always_comb begin
        needs_mem = icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
        mem_write = icode inside {IRMMOVQ, ICALL, IPUSHQ};
        needs_wb  = icode inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ,
                                  ICALL, IRET, IPUSHQ, IPOPQ};
        // cmovXX always visits WRITEBACK; only the register write is conditional
        we_e      = (icode inside {IIRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ}) ||
                    ((icode == IRRMOVQ) && cnd);
        we_m      = icode inside {IMRMOVQ, IPOPQ};
        sets_cc   = (icode == IOPQ);
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: FSM, memory-handshake timeout, retire count.
// Optional STAGE_SEQ_TRACE_EN adds trace_state output and simulation trace prints.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_WID  = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  run,
    input  logic [3:0]            icode,
    input  logic                  instr_valid,
    input  logic                  imem_error,
    input  logic                  dmem_error,
    input  logic                  Cnd,
    input  logic                  if_ack,
    input  logic                  mem_ack,
    output logic                  if_req,
    output logic                  ir_we,
    output logic                  cc_we,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  reg_we_e,
    output logic                  reg_we_m,
    output logic                  pc_we,
    output logic [3:0]            stat,
    output logic                  busy,
    output logic [RETIRE_WID-1:0] retired
`ifdef STAGE_SEQ_TRACE_EN
    ,
    output logic [2:0]            trace_state
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t                state, state_nxt;
    stat_t                 stat_q, stat_nxt;
    logic [CNT_W-1:0]      wait_cnt;
    logic [3:0]            icode_q;
    logic                  cnd_q;
    logic [RETIRE_WID-1:0] retired_q;
    logic                  timed_out;
    logic                  needs_mem, mem_write, needs_wb, we_e, we_m, sets_cc;

    icode_stage_decode u_decode (
        .icode     (icode_q),
        .cnd       (cnd_q),
        .needs_mem (needs_mem),
        .mem_write (mem_write),
        .needs_wb  (needs_wb),
        .we_e      (we_e),
        .we_m      (we_m),
        .sets_cc   (sets_cc)
    );

    assign timed_out = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        stat_nxt  = stat_q;
        case (state)
            IDLE:      if (run) state_nxt = FETCH;
            FETCH: begin
                // an ack on the final wait cycle takes priority over the timeout
                if (if_ack) begin
                    if (imem_error) begin
                        stat_nxt  = ADR;
                        state_nxt = HALT;
                    end else begin
                        state_nxt = DECODE;
                    end
                end else if (timed_out) begin
                    stat_nxt  = ADR;
                    state_nxt = HALT;
                end
            end
            DECODE: begin
                if (!instr_valid) begin
                    stat_nxt  = INS;
                    state_nxt = HALT;
                end else if (icode == IHALT) begin
                    stat_nxt  = HLT;
                    state_nxt = HALT;
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                if (needs_mem)     state_nxt = MEMORY;
                else if (needs_wb) state_nxt = WRITEBACK;
                else               state_nxt = PC_UPD;
            end
            MEMORY: begin
                if (mem_ack) begin
                    if (dmem_error) begin
                        stat_nxt  = ADR;
                        state_nxt = HALT;
                    end else begin
                        state_nxt = needs_wb ? WRITEBACK : PC_UPD;
                    end
                end else if (timed_out) begin
                    stat_nxt  = ADR;
                    state_nxt = HALT;
                end
            end
            WRITEBACK: state_nxt = PC_UPD;
            PC_UPD:    state_nxt = run ? FETCH : IDLE;
            HALT:      state_nxt = HALT;
            default:   state_nxt = IDLE;
        endcase
    end

    // ir_we is a DECODE decode: DECODE is only ever entered on a clean fetch ack
    always_comb begin
        if_req   = (state == FETCH);
        ir_we    = (state == DECODE);
        cc_we    = (state == EXECUTE) && sets_cc;
        mem_req  = (state == MEMORY);
        mem_we   = (state == MEMORY) && mem_write;
        reg_we_e = (state == WRITEBACK) && we_e;
        reg_we_m = (state == WRITEBACK) && we_m;
        pc_we    = (state == PC_UPD);
        busy     = (state != IDLE) && (state != HALT);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            stat_q    <= AOK;
            wait_cnt  <= '0;
            icode_q   <= '0;
            cnd_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state  <= state_nxt;
            stat_q <= stat_nxt;
            // FETCH/MEMORY never self-re-enter, so staying implies still waiting
            if (((state == FETCH) || (state == MEMORY)) && (state_nxt == state))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (state == DECODE)  icode_q <= icode;
            if (state == EXECUTE) cnd_q   <= Cnd;
            if (state == PC_UPD)  retired_q <= retired_q + RETIRE_WID'(1);
`ifdef STAGE_SEQ_TRACE_EN
            if (state == PC_UPD)
                $display("stage_sequencer: retire retired=%0d icode=%0h stat=%0d",
                         retired_q + RETIRE_WID'(1), icode_q, stat_q);
            if ((state_nxt == HALT) && (state != HALT))
                $display("stage_sequencer: halt retired=%0d icode=%0h stat=%0d",
                         retired_q, icode, stat_nxt);
`endif
        end
    end

    assign stat    = stat_q;
    assign retired = retired_q;
`ifdef STAGE_SEQ_TRACE_EN
    assign trace_state = state;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed scoreboard bench for stage_sequencer: per-cycle expected strobes
// and status are queued with the stimulus and compared as the run proceeds.
module tb_stage_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        run;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        dmem_error;
    logic        Cnd;
    logic        if_ack;
    logic        mem_ack;
    logic        if_req, ir_we, cc_we, mem_req, mem_we;
    logic        reg_we_e, reg_we_m, pc_we, busy;
    logic [3:0]  stat;
    logic [31:0] retired;
`ifdef STAGE_SEQ_TRACE_EN
    logic [2:0]  trace_state;
`endif

    always #5 CLK = ~CLK;

    stage_sequencer #(.MEM_TIMEOUT(16), .RETIRE_WID(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .run         (run),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .Cnd         (Cnd),
        .if_ack      (if_ack),
        .mem_ack     (mem_ack),
        .if_req      (if_req),
        .ir_we       (ir_we),
        .cc_we       (cc_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_we_e    (reg_we_e),
        .reg_we_m    (reg_we_m),
        .pc_we       (pc_we),
        .stat        (stat),
        .busy        (busy),
        .retired     (retired)
`ifdef STAGE_SEQ_TRACE_EN
        ,
        .trace_state (trace_state)
`endif
    );

    // strobe vector: {if_req, ir_we, cc_we, mem_req, mem_we, reg_we_e, reg_we_m, pc_we, busy}
    logic [8:0] obs_v;
    assign obs_v = {if_req, ir_we, cc_we, mem_req, mem_we, reg_we_e, reg_we_m, pc_we, busy};

    localparam logic [8:0] EZ  = 9'h000;
    localparam logic [8:0] EF  = 9'h101;
    localparam logic [8:0] ED  = 9'h081;
    localparam logic [8:0] EE  = 9'h001;
    localparam logic [8:0] ECC = 9'h041;
    localparam logic [8:0] EM  = 9'h021;
    localparam logic [8:0] EMW = 9'h031;
    localparam logic [8:0] EP  = 9'h003;
    localparam logic [8:0] BWE = 9'h008;
    localparam logic [8:0] BWM = 9'h004;

    typedef struct packed {
        logic [3:0] icode;
        logic       valid;
        logic       cnd;
        logic       ifa;
        logic       mema;
        logic       ie;
        logic       de;
        logic       rn;
        logic [8:0] exp;
        logic [3:0] st;
    } cyc_t;

    cyc_t  sb[$];
    int    n_total = 0;
    int    n_pass  = 0;
    string tag;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic push(input logic [3:0] ic, input logic valid, input logic cnd,
                        input logic ifa, input logic mema, input logic ie, input logic de,
                        input logic rn, input logic [8:0] e, input logic [3:0] st);
        cyc_t c;
        c.icode = ic; c.valid = valid; c.cnd = cnd; c.ifa = ifa; c.mema = mema;
        c.ie = ie; c.de = de; c.rn = rn; c.exp = e; c.st = st;
        sb.push_back(c);
    endtask

    task automatic drain();
        cyc_t c;
        int   k;
        k = 0;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            icode = c.icode; instr_valid = c.valid; Cnd = c.cnd;
            if_ack = c.ifa; mem_ack = c.mema; imem_error = c.ie; dmem_error = c.de;
            run = c.rn;
            chk($sformatf("%s cyc%0d strobes", tag, k), 32'(obs_v), 32'(c.exp));
            chk($sformatf("%s cyc%0d stat", tag, k), 32'(stat), 32'(c.st));
            step();
            k++;
        end
        if_ack = 1'b0; mem_ack = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    endtask

    // One full instruction from its first FETCH cycle; Cnd is driven to the
    // wrong value outside EXECUTE so only the EXECUTE sample can matter.
    task automatic plan_instr(input logic [3:0] ic, input logic cnd, input int fw,
                              input int mw, input logic last);
        logic       mem, wr, wb, we, wm;
        logic [8:0] wexp;
        mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        wr  = ic inside {4'h4, 4'h8, 4'hA};
        wb  = mem ? (ic inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) : (ic inside {4'h2, 4'h3, 4'h6});
        we  = (ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && cnd);
        wm  = ic inside {4'h5, 4'hB};
        for (int i = 0; i < fw; i++) push(ic, 1'b1, !cnd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        push(ic, 1'b1, !cnd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        push(ic, 1'b1, !cnd, 1'b0, 1'b0, 1'b0, 1'b0, !last, ED, 4'd1);
        push(ic, 1'b1, cnd, 1'b0, 1'b0, 1'b0, 1'b0, !last, (ic == 4'h6) ? ECC : EE, 4'd1);
        if (mem) begin
            for (int i = 0; i < mw; i++)
                push(ic, 1'b1, !cnd, 1'b0, 1'b0, 1'b0, 1'b0, !last, wr ? EMW : EM, 4'd1);
            push(ic, 1'b1, !cnd, 1'b0, 1'b1, 1'b0, 1'b0, !last, wr ? EMW : EM, 4'd1);
        end
        if (wb) begin
            wexp = EE | (we ? BWE : EZ) | (wm ? BWM : EZ);
            push(ic, 1'b1, !cnd, 1'b0, 1'b0, 1'b0, 1'b0, !last, wexp, 4'd1);
        end
        push(ic, 1'b1, !cnd, 1'b0, 1'b0, 1'b0, 1'b0, !last, EP, 4'd1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; run = 1'b0; if_ack = 1'b0; mem_ack = 1'b0;
        imem_error = 1'b0; dmem_error = 1'b0; Cnd = 1'b0; icode = 4'h1; instr_valid = 1'b1;
        step();
        chk("reset strobes", 32'(obs_v), 32'(EZ));
        chk("reset stat", 32'(stat), 32'd1);
        chk("reset retired", retired, 32'd0);
        RST_N = 1'b1;
    endtask

    task automatic start();
        chk({tag, " idle strobes"}, 32'(obs_v), 32'(EZ));
        run = 1'b1;
        step();
    endtask

    initial begin
        do_reset();
        do_reset();

        tag = "irmovq";  start();
        plan_instr(4'h3, 1'b0, 0, 0, 1'b0); drain();
        chk("irmovq retired", retired, 32'd1);
        tag = "pushq";   plan_instr(4'hA, 1'b0, 0, 3, 1'b0); drain();
        chk("pushq retired", retired, 32'd2);
        tag = "cmov_c0"; plan_instr(4'h2, 1'b0, 0, 0, 1'b0); drain();
        tag = "cmov_c1"; plan_instr(4'h2, 1'b1, 0, 0, 1'b0); drain();
        tag = "opq";     plan_instr(4'h6, 1'b1, 1, 0, 1'b0); drain();
        tag = "mrmovq";  plan_instr(4'h5, 1'b0, 2, 1, 1'b0); drain();
        tag = "rmmovq";  plan_instr(4'h4, 1'b0, 0, 0, 1'b0); drain();
        tag = "jxx";     plan_instr(4'h7, 1'b1, 0, 0, 1'b0); drain();
        tag = "call";    plan_instr(4'h8, 1'b0, 0, 2, 1'b0); drain();
        tag = "ret";     plan_instr(4'h9, 1'b0, 0, 0, 1'b0); drain();
        tag = "popq_ack_at_limit"; plan_instr(4'hB, 1'b0, 15, 15, 1'b1); drain();
        chk("seq retired", retired, 32'd11);
        for (int i = 0; i < 3; i++) begin
            chk("parked strobes", 32'(obs_v), 32'(EZ));
            step();
        end

        tag = "rst_mid_mem"; start();
        icode = 4'h4; instr_valid = 1'b1; if_ack = 1'b1; step();
        if_ack = 1'b0; step(); step();
        chk("mem held 1", 32'(obs_v), 32'(EMW));
        step();
        chk("mem held 2", 32'(obs_v), 32'(EMW));
        RST_N = 1'b0; step();
        RST_N = 1'b1; run = 1'b0;
        chk("rst_mid_mem strobes", 32'(obs_v), 32'(EZ));
        chk("rst_mid_mem stat", 32'(stat), 32'd1);
        chk("rst_mid_mem retired", retired, 32'd0);

        tag = "prog"; start();
        plan_instr(4'h1, 1'b0, 0, 0, 1'b0);
        plan_instr(4'h1, 1'b0, 0, 0, 1'b0);
        push(4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        push(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ED, 4'd1);
        for (int i = 0; i < 5; i++) push(4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, EZ, 4'd2);
        drain();
        chk("prog retired", retired, 32'd2);

        tag = "invalid"; do_reset(); start();
        plan_instr(4'h1, 1'b0, 0, 0, 1'b0);
        push(4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        push(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ED, 4'd1);
        for (int i = 0; i < 4; i++) push(4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, EZ, 4'd4);
        drain();
        chk("invalid retired", retired, 32'd1);

        tag = "fetch_timeout"; do_reset(); start();
        for (int i = 0; i < 16; i++) push(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        for (int i = 0; i < 50; i++)
            push(4'h1, 1'b1, 1'b0, 1'(i % 2), 1'(i % 3 == 0), 1'b0, 1'b0, 1'b1, EZ, 4'd3);
        drain();
        chk("timeout retired", retired, 32'd0);

        tag = "imem_err"; do_reset(); start();
        push(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, EF, 4'd1);
        for (int i = 0; i < 3; i++) push(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EZ, 4'd3);
        drain();

        tag = "dmem_err"; do_reset(); start();
        push(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EF, 4'd1);
        push(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ED, 4'd1);
        push(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EE, 4'd1);
        push(4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, EM, 4'd1);
        for (int i = 0; i < 3; i++) push(4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, EZ, 4'd3);
        drain();
        chk("dmem_err retired", retired, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle controller that sequences the Y86 datapath (PC, instruction memory, register file, ALU/CC, data memory) through fetch → decode → execute → memory → writeback → PC update, one stage per state.
- Generates all stage write-enables and memory requests, waits on memory handshakes, skips unused stages per icode, and owns the processor status code.
- Sits between the CPU top and the existing datapath modules, replacing free-running single-cycle updates.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for if_ack/mem_ack before faulting with ADR; minimum 1.
- RETIRE_WID, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- run  in  1  level enable; the sequencer leaves IDLE only while high.
- icode  in  4  instruction code from the instruction memory decode.
- instr_valid  in  1  decoded instruction legal; sampled in DECODE.
- imem_error  in  1  fetch address error; sampled with if_ack.
- dmem_error  in  1  data address error; sampled with mem_ack.
- Cnd  in  1  condition result from the ALU; sampled in EXECUTE.
- if_ack  in  1  instruction fetch complete.
- mem_ack  in  1  data memory access complete.
- if_req  out  1  fetch request.
- ir_we  out  1  latch fetched fields.
- cc_we  out  1  condition-code update.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (valid only with mem_req).
- reg_we_e  out  1  write valE to register file.
- reg_we_m  out  1  write valM to register file.
- pc_we  out  1  PC update.
- stat  out  4  status code: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in every state except IDLE and HALT.
- retired  out  RETIRE_WID  count of instructions that completed PC_UPD.

Behaviour:
- Reset (RST_N low at an edge): state=IDLE, stat=AOK, retired=0, all strobes 0, timeout counter 0. Takes effect from any state, including mid-handshake; pending requests drop the same cycle.
- State transitions:
  - IDLE → FETCH when run=1.
  - FETCH:
    - if_req=1 while waiting.
    - On if_ack: if imem_error, stat=ADR and go to HALT. Otherwise ir_we pulses for 1 cycle and go to DECODE.
  - DECODE:
    - If instr_valid=0: stat=INS, go to HALT.
    - If icode=0 (halt): stat=HLT, go to HALT.
    - Otherwise go to EXECUTE.
  - EXECUTE: cc_we=1 for one cycle iff icode=6 (OPq); Cnd is captured.
    - Go to MEMORY if icode ∈ {4,5,8,9,A,B}.
    - Else go to WRITEBACK if icode ∈ {2,3,6}.
    - Else go to PC_UPD.
  - MEMORY:
    - mem_req=1 is held until mem_ack. mem_we=1 for icode ∈ {4,8,A}.
    - On mem_ack: if dmem_error, stat=ADR and go to HALT. Otherwise go to WRITEBACK if icode ∈ {5,8,9,A,B}, else go to PC_UPD.
  - WRITEBACK, one cycle, then PC_UPD:
    - reg_we_e for icode ∈ {3,6,8,9,A,B}, and for icode 2 only if the captured Cnd=1.
    - reg_we_m for icode ∈ {5,B}.
  - PC_UPD: pc_we=1 for one cycle and retired+1 (wraps modulo 2^RETIRE_WID). Then go to FETCH if run=1, else IDLE.
  - HALT: absorbing; all strobes 0, stat frozen; exited only by reset.
- Timeout: a counter clears on entry to FETCH/MEMORY. If the ack has not arrived after MEM_TIMEOUT cycles in that state, stat=ADR and go to HALT. An ack arriving on the timeout cycle wins.
- A faulting instruction never asserts pc_we, reg_we_*, or increments retired.
- Strobes are registered-state decodes with no combinational path from acks to strobes, except that leaving the state on ack drops the request the next cycle.
- Minimum latency per instruction: 4 cycles (nop/jXX: F, D, E, P) plus ack waits; maximum 6 cycles plus waits.
- run falling mid-instruction does not abort; the instruction completes, then the sequencer parks in IDLE.

Optional Feature:
- STAGE_SEQ_TRACE_EN:
  - Defined: adds output trace_state (3 bits, current state encoding) and a simulation-only $display on every PC_UPD and HALT entry (retired, icode, stat).
  - Undefined: the port and displays are absent; behaviour is otherwise identical.

Decomposition:
- Shared header (alongside the existing DATA_WID header):
  - state encodings IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PC_UPD/HALT;
  - stat codes AOK/HLT/ADR/INS;
  - icode constants IHALT..IPOPQ.
- One natural sub-module, icode_stage_decode: combinational needs_mem/mem_write/needs_wb/we_e/we_m/sets_cc from icode and Cnd.
- FSM, timeout counter and retire counter stay in stage_sequencer.

Test Plan:
- Reset mid-MEMORY with mem_req=1, RST_N low 1 cycle → next cycle state=IDLE, mem_req=0, stat=1, retired=0.
- irmovq (icode 3), acks immediate → if_req, ir_we, (D), (E), reg_we_e, pc_we: 5 cycles after FETCH entry; cc_we never high; retired=1.
- pushq (icode A), mem_ack delayed 3 cycles → mem_req, mem_we high exactly 4 cycles; then reg_we_e 1 cycle, pc_we 1 cycle.
- cmovXX (icode 2) with Cnd=0 → no reg_we_e; pc_we=1. Repeat with Cnd=1 → reg_we_e=1.
- if_ack never arrives, MEM_TIMEOUT=16 → stat=3 after 16 FETCH cycles, HALT, busy=0, no further strobes for 50 cycles.
- Program nop, nop, halt → retired=2, stat=2, pc_we pulsed twice; instr_valid=0 on a separate run → stat=4, retired unchanged.
